// File: rtl/gen_frame_out_buffer.sv
// Ping-pong frame buffer behind the generator pixel stream. It captures one OUT_W x OUT_H
// image per armed frame and replays it on a valid/ready stream that carries an end-of-frame marker.
module gen_frame_out_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_W      = 28,
    parameter int OUT_H      = 28,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done,
    output logic [15:0]           drop_cnt,
    output logic                  overflow
);
    localparam int PIXELS = OUT_W * OUT_H;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = '0;

    typedef enum logic {C_IDLE, C_FILL} cap_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_t;

    // Handshake: a pixel moves when out_valid && out_ready on a rising edge; while
    // out_valid is high and out_ready is low, out_data/out_last hold and out_valid stays high.

    cap_state_t cap_state;
    rd_state_t  rd_state;

    logic [DATA_WIDTH-1:0] mem [2][2**ADDR_W];
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_W-1:0]     wr_cnt;
    logic [ADDR_W-1:0]     rd_cnt;
    logic [ADDR_W-1:0]     rd_nxt;
    logic [ADDR_W-1:0]     base_cnt;
    logic                  accept;
    logic                  wr_en;
    logic                  wr_last;
    logic                  drop;
    logic                  hs;
    logic                  full_clr;

    // frame_start takes priority, so a pixel arriving with it becomes pixel 0 of the new frame
    always_comb begin
        accept   = frame_start ? ~full[wr_bank] : (cap_state == C_FILL);
        base_cnt = frame_start ? FIRST_IDX : wr_cnt;
        wr_en    = accept & in_valid;
        wr_last  = wr_en && (base_cnt == LAST_IDX);
        drop     = in_valid & ~accept;
        hs       = out_valid & out_ready;
        full_clr = (rd_state == R_STREAM) && hs && out_last;
        rd_nxt   = rd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][base_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state  <= C_IDLE;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            frame_done <= 1'b0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= wr_last;
            if (frame_start && full[wr_bank]) begin
                overflow <= 1'b1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (wr_last) begin
                cap_state <= C_IDLE;
                wr_bank   <= ~wr_bank;
                wr_cnt    <= '0;
            end else if (accept) begin
                cap_state <= C_FILL;
                wr_cnt    <= wr_en ? base_cnt + 1'b1 : base_cnt;
            end else begin
                cap_state <= C_IDLE;
            end
        end
    end

    // Set and clear always address different banks, so both updates land together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (wr_last) begin
                full[wr_bank] <= 1'b1;
            end
            if (full_clr) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // out_data is the synchronous read register; it is reloaded only on a handshake,
    // so it always holds the pixel currently presented and the next one arrives bubble-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        out_data <= mem[rd_bank][FIRST_IDX];
                        rd_cnt   <= FIRST_IDX;
                        rd_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    out_valid <= 1'b1;
                    out_last  <= (LAST_IDX == FIRST_IDX);
                    rd_state  <= R_STREAM;
                end
                R_STREAM: begin
                    if (hs) begin
                        if (out_last) begin
                            rd_bank <= ~rd_bank;
                            rd_cnt  <= FIRST_IDX;
                            if (full[~rd_bank]) begin
                                out_data <= mem[~rd_bank][FIRST_IDX];
                                out_last <= (LAST_IDX == FIRST_IDX);
                            end else begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                rd_state  <= R_IDLE;
                            end
                        end else begin
                            rd_cnt   <= rd_nxt;
                            out_data <= mem[rd_bank][rd_nxt];
                            out_last <= (rd_nxt == LAST_IDX);
                        end
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_frame_out_buffer.sv
// Bench for gen_frame_out_buffer: a frame-level reference model fills an expected queue
// that an independent monitor drains on every output handshake.
module tb_gen_frame_out_buffer;
    localparam int DW     = 16;
    localparam int PIXELS = 28 * 28;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          frame_start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_done;
    logic [15:0]   drop_cnt;
    logic          overflow;

    gen_frame_out_buffer #(
        .DATA_WIDTH(DW),
        .OUT_W     (28),
        .OUT_H     (28),
        .ADDR_W    (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: {last, data} per expected output pixel
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] part_q[$];
    int            n_buf;
    int            exp_fd;
    int            fd_cnt;
    int            hs_cnt;
    logic          armed;
    logic          exp_ovf;
    logic [15:0]   exp_drop;
    int            ready_mode;
    int            ready_step;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        part_q.delete();
        n_buf    = 0;
        exp_fd   = 0;
        fd_cnt   = 0;
        armed    = 1'b0;
        exp_ovf  = 1'b0;
        exp_drop = 16'd0;
    endtask

    // one input cycle; the model applies frame_start before the pixel
    task automatic drive(input logic fs, input logic iv, input logic [DW-1:0] d);
        frame_start = fs;
        in_valid    = iv;
        in_data     = d;
        if (fs) begin
            if (n_buf == 2) begin
                exp_ovf = 1'b1;
                armed   = 1'b0;
            end else begin
                armed = 1'b1;
                part_q.delete();
            end
        end
        if (iv) begin
            if (armed) begin
                part_q.push_back(d);
                if (part_q.size() == PIXELS) begin
                    for (int i = 0; i < PIXELS; i++) begin
                        exp_q.push_back({(i == PIXELS - 1) ? 1'b1 : 1'b0, part_q[i]});
                    end
                    n_buf++;
                    exp_fd++;
                    armed = 1'b0;
                    part_q.delete();
                end
            end else if (exp_drop != 16'hFFFF) begin
                exp_drop = exp_drop + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit rand_data, input bit gaps, input bit fs_with_first);
        logic [DW-1:0] d;
        if (!fs_with_first) drive(1'b1, 1'b0, '0);
        for (int i = 0; i < PIXELS; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, '0);
            end
            d = rand_data ? DW'($urandom) : DW'(base + i);
            drive(fs_with_first && (i == 0), 1'b1, d);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(posedge clk);
            #1;
            b++;
        end
        check(name, exp_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        check({name, "_idle"}, out_valid, 0);
    endtask

    // out_ready pattern generator
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ready_step < 8) ? (ready_step % 2 == 0) : ($urandom_range(0, 1) == 1);
                    ready_step++;
                end
                2: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // scoreboard monitor
    logic          stall_prev = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    logic [DW:0]   e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (frame_done) fd_cnt++;
                if (stall_prev) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, hold_d);
                    check("stall_last", out_last, hold_l);
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got pixel %0d, expected no output (t=%0t)", out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e[DW-1:0]);
                        check("out_last", out_last, e[DW]);
                        if (e[DW]) n_buf--;
                    end
                end
                stall_prev = out_valid && !out_ready;
                hold_d     = out_data;
                hold_l     = out_last;
            end
        end
    end

    // main sequence
    initial begin
        int base;
        int b;
        int vcount;
        ready_mode = 0;
        ready_step = 0;
        hs_cnt     = 0;

        // 1: single ramp frame, always ready
        do_reset();
        send_frame(0, 1'b0, 1'b0, 1'b0);
        wait_drain("t1_drain", 2000);
        check("t1_frame_done", fd_cnt, exp_fd);
        check("t1_drop_cnt", drop_cnt, exp_drop);
        check("t1_overflow", overflow, exp_ovf);

        // 2: random-data frame followed by a zero flush
        do_reset();
        send_frame(0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) drive(1'b0, 1'b1, '0);
        wait_drain("t2_drain", 2000);
        check("t2_drop_cnt", drop_cnt, exp_drop);
        check("t2_frame_done", fd_cnt, exp_fd);

        // 3: toggling then random out_ready, input gaps, frame_start with pixel 0
        do_reset();
        ready_step = 0;
        ready_mode = 1;
        send_frame(0, 1'b0, 1'b1, 1'b1);
        wait_drain("t3_drain", 6000);
        check("t3_drop_cnt", drop_cnt, exp_drop);
        ready_mode = 0;

        // 4: no ready, three frames: third overflows and is dropped
        do_reset();
        ready_mode = 2;
        send_frame(0, 1'b0, 1'b0, 1'b0);
        send_frame(1000, 1'b0, 1'b0, 1'b0);
        send_frame(2000, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("t4_overflow", overflow, exp_ovf);
        check("t4_drop_cnt", drop_cnt, exp_drop);
        check("t4_frame_done", fd_cnt, exp_fd);
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_data", out_data, exp_q[0][DW-1:0]);
        ready_mode = 0;
        wait_drain("t4_drain", 4000);

        // 5: aborted partial frame
        do_reset();
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, DW'(i));
        send_frame(5000, 1'b0, 1'b0, 1'b0);
        wait_drain("t5_drain", 2000);
        check("t5_frame_done", fd_cnt, exp_fd);
        check("t5_drop_cnt", drop_cnt, exp_drop);

        // 6: reset during readout of pixel 100
        do_reset();
        send_frame(0, 1'b0, 1'b0, 1'b0);
        base = hs_cnt;
        b = 0;
        while (hs_cnt < base + 100 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check("t6_reach_px100", (hs_cnt >= base + 100), 1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_last", out_last, 0);
        check("t6_async_data", out_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) vcount++;
        end
        check("t6_no_stale", vcount, 0);
        send_frame(300, 1'b0, 1'b0, 1'b0);
        wait_drain("t6_drain", 2000);

        // 7: random traffic, three back-to-back frames with random ready
        do_reset();
        ready_mode = 3;
        for (int f = 0; f < 3; f++) send_frame(0, 1'b1, 1'b1, ($urandom_range(0, 1) == 1));
        ready_mode = 0;
        wait_drain("t7_drain", 6000);
        check("t7_overflow", overflow, exp_ovf);
        check("t7_drop_cnt", drop_cnt, exp_drop);
        check("t7_frame_done", fd_cnt, exp_fd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_frame_out_buffer.md
Name: gen_frame_out_buffer

Overview:
- Sits directly downstream of the generator_v3 pixel stream (valid_out/data_out).
- Captures exactly one 28x28 output image per frame into a two-bank (ping-pong) frame buffer.
- Drops all surplus pixels, including the zero-pad flush that trails each frame.
- Replays each captured frame on a valid/ready stream with an end-of-frame marker. This makes frame alignment a hardware function rather than a bench filter.

Parameters:
- DATA_WIDTH, 16, pixel width (signed fixed-point, passed through unchanged).
- OUT_W, 28, output image width in pixels.
- OUT_H, 28, output image height in pixels.
- ADDR_W, 10, bank address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H.
- PIXELS is a derived local constant, OUT_W*OUT_H (784 at defaults).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse that arms capture of a new frame.
- in_valid  in  1  generator pixel strobe (generator valid_out).
- in_data  in  DATA_WIDTH  generator pixel (generator data_out).
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the pixel when out_valid and out_ready are both 1.
- out_data  out  DATA_WIDTH  output pixel, raster order.
- out_last  out  1  high with the final (PIXELS-th) pixel of a frame.
- frame_done  out  1  one-cycle pulse when a bank has been completely filled.
- drop_cnt  out  16  saturating count of discarded in_valid pixels.
- overflow  out  1  sticky flag: frame_start arrived while both banks were full.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; both bank-full flags clear.
  - wr_bank=0, rd_bank=0, counters 0, both FSMs idle.
  - Memory contents are not reset and must never be visible at the output after reset.
- Capture FSM, states C_IDLE and C_FILL:
  - C_IDLE: every in_valid is dropped and drop_cnt increments, saturating at 16'hFFFF.
  - frame_start with full[wr_bank]==0: go to C_FILL with wr_cnt=0.
  - frame_start with full[wr_bank]==1: set overflow, stay in C_IDLE, and drop all following pixels.
  - C_FILL: each in_valid writes mem[wr_bank][wr_cnt] and increments wr_cnt.
  - On the write where wr_cnt==PIXELS-1: set full[wr_bank], toggle wr_bank, pulse frame_done on the next cycle, return to C_IDLE.
  - frame_start during C_FILL aborts the partial frame: wr_cnt restarts at 0 in the same bank, and no frame_done is produced for the partial frame.
  - frame_start and in_valid in the same cycle: frame_start takes effect first, and that pixel is stored as pixel 0 of the new frame (not counted as dropped).
- Readout FSM, states R_IDLE, R_FETCH, R_STREAM:
  - R_IDLE: when full[rd_bank]==1, issue a read of address 0 and go to R_FETCH.
  - Memory read is synchronous with 1-cycle latency. R_FETCH loads an output register; out_valid rises in R_STREAM.
  - Latency: out_valid is high no later than 2 cycles after frame_done pulses, if the read bank is idle.
  - While out_valid=1 and out_ready=0: out_data and out_last hold stable.
  - On each handshake, the next pixel is presented the following cycle with no bubbles. Continuous out_ready=1 sustains 1 pixel/cycle, so prefetch or a skid register is required.
  - On the handshake with out_last=1: clear full[rd_bank], toggle rd_bank. Then either continue directly into the next full bank (out_valid may bubble at most 1 cycle) or return to R_IDLE.
- Simultaneous set and clear of the full flags always target different banks and must both take effect.
- Ordering: frames are emitted strictly in capture order; pixels are emitted in raster order, index 0..PIXELS-1.
- Arithmetic: data is passed through bit-exact with no sign or width change. wr_cnt and rd_cnt are ADDR_W bits and never exceed PIXELS-1.
- Reset mid-operation: outputs drop to 0 immediately. A partially read or written frame is discarded, and no stale data is emitted afterward.

Test Plan:
1. Reset, frame_start, 784 pixels with values 0..783, out_ready=1 → out_data 0..783 in order; out_last only on 783; exactly one frame_done; drop_cnt=0; overflow=0.
2. Frame of 784 pixels followed by 200 in_valid zeros (flush) → exactly 784 outputs; drop_cnt=200.
3. Frame of 784 ramp pixels with out_ready toggling 1,0,1,0 then randomised → sequence 0..783 intact; out_data stable during every stall; no duplicated or skipped pixels.
4. out_ready=0, three frames (A=ramp from 0, B=ramp from 1000, C=ramp from 2000), each preceded by frame_start → A and B captured; overflow=1 at C's frame_start; drop_cnt=784. Raise out_ready → A then B emitted, C absent.
5. frame_start, 300 pixels, frame_start, 784 pixels (ramp from 5000) → only 5000..5783 emitted; one frame_done.
6. During readout of pixel 100, pulse rst_n low for 3 cycles → out_valid=0 asynchronously; after release no output until a new frame_start plus 784 pixels; then a clean frame is emitted.
